// File: rtl/register_file.sv
// 32x8 register file, two registered read ports, one write port; 1-cycle read latency.
// Reads and writes are always accepted; a same-edge write is bypassed to matching read ports.
module register_file #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        A1,
  input  logic [7:0]        A2,
  input  logic [7:0]        A3,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              regWriteEnable,
  input  logic              regReadEnable,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int         IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NREG_L = 9'(NUM_REGS);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_hit;

  assign wr_hit = regWriteEnable && ({1'b0, A3} < NREG_L);

  // Out-of-range addresses read as zero; a matching same-edge write wins over the stored value.
  function automatic logic [DATA_W-1:0] rd_val(input logic [7:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if ({1'b0, a} < NREG_L) begin
      if (wr_hit && (a == A3)) v = WriteData;
      else                     v = mem[a[IDX_W-1:0]];
    end
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[A3[IDX_W-1:0]] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RD1 <= '0;
      RD2 <= '0;
    end else if (regReadEnable) begin
      RD1 <= rd_val(A1);
      RD2 <= rd_val(A2);
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, reset-in-flight sequence, random traffic vs. array model.
module tb_register_file;

  logic       clk;
  logic       rst_n;
  logic [7:0] A1, A2, A3, WriteData;
  logic       regWriteEnable, regReadEnable;
  logic [7:0] RD1, RD2;

  int n_vec;
  int n_err;

  logic [7:0] m_mem [32];
  logic [7:0] m_rd1, m_rd2;

  typedef struct packed {
    logic       we;
    logic       re;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] wd;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t tbl [16];

  register_file #(.NUM_REGS(32), .DATA_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A1(A1),
    .A2(A2),
    .A3(A3),
    .WriteData(WriteData),
    .regWriteEnable(regWriteEnable),
    .regReadEnable(regReadEnable),
    .RD1(RD1),
    .RD2(RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_val(input logic [7:0] a, input logic we,
                                         input logic [7:0] a3, input logic [7:0] wd);
    if (a >= 8'd32) return 8'h00;
    if (we && (a == a3)) return wd;
    return m_mem[a[4:0]];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_rd1 = 8'h00;
    m_rd2 = 8'h00;
  endtask

  // Drive on the falling edge, let the rising edge happen, update the model, sample 1 time unit later.
  task automatic step(input logic we, input logic re, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] a3, input logic [7:0] wd);
    logic [7:0] n1, n2;
    @(negedge clk);
    regWriteEnable = we;
    regReadEnable  = re;
    A1 = a1; A2 = a2; A3 = a3; WriteData = wd;
    @(posedge clk);
    n1 = ref_val(a1, we, a3, wd);
    n2 = ref_val(a2, we, a3, wd);
    if (re) begin
      m_rd1 = n1;
      m_rd2 = n2;
    end
    if (we && (a3 < 8'd32)) m_mem[a3[4:0]] = wd;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    rst_n = 1'b0;
    regWriteEnable = 1'b0; regReadEnable = 1'b0;
    A1 = 8'h00; A2 = 8'h00; A3 = 8'h00; WriteData = 8'h00;

    //            we    re    a1      a2      a3      wd      e1      e2
    tbl[0]  = '{1'b0, 1'b1, 8'd0,   8'd1,   8'd0,   8'd0,   8'd0,   8'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'd0,   8'd0,   8'd2,   8'd42,  8'd0,   8'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'd2,   8'd1,   8'd0,   8'd0,   8'd42,  8'd0};
    tbl[3]  = '{1'b1, 1'b0, 8'd0,   8'd0,   8'd4,   8'd99,  8'd42,  8'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'd4,   8'd2,   8'd0,   8'd0,   8'd99,  8'd42};
    tbl[5]  = '{1'b1, 1'b0, 8'd0,   8'd0,   8'd1,   8'd67,  8'd99,  8'd42};
    tbl[6]  = '{1'b0, 1'b1, 8'd1,   8'd2,   8'd0,   8'd0,   8'd67,  8'd42};
    tbl[7]  = '{1'b0, 1'b0, 8'd5,   8'd6,   8'd0,   8'd0,   8'd67,  8'd42};
    tbl[8]  = '{1'b1, 1'b1, 8'd3,   8'd4,   8'd3,   8'hA5,  8'hA5,  8'd99};
    tbl[9]  = '{1'b1, 1'b1, 8'd40,  8'd40,  8'd40,  8'd77,  8'd0,   8'd0};
    tbl[10] = '{1'b0, 1'b1, 8'd8,   8'd1,   8'd0,   8'd0,   8'd0,   8'd67};
    tbl[11] = '{1'b0, 1'b1, 8'd2,   8'd2,   8'd0,   8'd0,   8'd42,  8'd42};
    tbl[12] = '{1'b1, 1'b1, 8'd0,   8'd3,   8'd0,   8'h11,  8'h11,  8'hA5};
    tbl[13] = '{1'b1, 1'b1, 8'd31,  8'd0,   8'd31,  8'hEE,  8'hEE,  8'h11};
    tbl[14] = '{1'b1, 1'b1, 8'd2,   8'd4,   8'd4,   8'h5C,  8'd42,  8'h5C};
    tbl[15] = '{1'b0, 1'b1, 8'd255, 8'd32,  8'd0,   8'd0,   8'd0,   8'd0};

    #12;
    check("reset_rd1", RD1, 8'h00);
    check("reset_rd2", RD2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].wd);
      check($sformatf("vec%0d_rd1", i), RD1, tbl[i].e1);
      check($sformatf("vec%0d_rd2", i), RD2, tbl[i].e2);
    end

    // Reset between edges clears outputs at once and swallows a write presented while held.
    step(1'b0, 1'b1, 8'd2, 8'd4, 8'd0, 8'd0);
    check("pre_rst_rd1", RD1, 8'd42);
    check("pre_rst_rd2", RD2, 8'h5C);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd1", RD1, 8'h00);
    check("async_rst_rd2", RD2, 8'h00);
    regWriteEnable = 1'b1; A3 = 8'd5; WriteData = 8'h33;
    regReadEnable = 1'b1; A1 = 8'd2; A2 = 8'd5;
    @(posedge clk);
    #1;
    check("rst_hold_rd1", RD1, 8'h00);
    check("rst_hold_rd2", RD2, 8'h00);
    @(negedge clk);
    regWriteEnable = 1'b0; regReadEnable = 1'b0;
    rst_n = 1'b1;
    model_clear();
    step(1'b0, 1'b1, 8'd2, 8'd4, 8'd0, 8'd0);
    check("post_rst_r2", RD1, 8'h00);
    check("post_rst_r4", RD2, 8'h00);
    step(1'b0, 1'b1, 8'd5, 8'd31, 8'd0, 8'd0);
    check("post_rst_r5", RD1, 8'h00);
    check("post_rst_r31", RD2, 8'h00);

    for (int i = 0; i < 400; i++) begin
      logic       we, re;
      logic [7:0] a1, a2, a3, wd;
      we = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 4) != 0);
      a3 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 33));
      a1 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 33));
      a2 = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 33));
      if ($urandom_range(0, 3) == 0) a1 = a3;
      if ($urandom_range(0, 3) == 0) a2 = a3;
      wd = 8'($urandom_range(0, 255));
      step(we, re, a1, a2, a3, wd);
      check("rand_rd1", RD1, m_rd1);
      check("rand_rd2", RD2, m_rd2);
    end

    for (int i = 0; i < 32; i += 2) begin
      step(1'b0, 1'b1, 8'(i), 8'(i + 1), 8'd0, 8'd0);
      check($sformatf("dump_r%0d", i), RD1, m_mem[i]);
      check($sformatf("dump_r%0d", i + 1), RD2, m_mem[i + 1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port A1, input, 8 bits: read address for port 1.
REQ-005 Port A2, input, 8 bits: read address for port 2.
REQ-006 Port A3, input, 8 bits: write address.
REQ-007 Port WriteData, input, 8 bits: data to be written.
REQ-008 Port regWriteEnable, input, 1 bit: active-high write enable.
REQ-009 Port regReadEnable, input, 1 bit: active-high read enable, common to both read ports.
REQ-010 Port RD1, output, 8 bits: registered read data for port 1.
REQ-011 Port RD2, output, 8 bits: registered read data for port 2.
REQ-012 Parameter NUM_REGS, default 32: number of storage registers.
REQ-013 Parameter DATA_W, default 8: register width.

Function
REQ-014 Storage SHALL be an array of 32 registers, each 8 bits wide, indexed 0..31; register 0 SHALL be an ordinary writable register.
REQ-015 The write SHALL occur on the rising clk edge when regWriteEnable=1 and A3<32: reg[A3] <= WriteData.
REQ-016 A write with A3>=32 SHALL be ignored and leave all registers unchanged.
REQ-017 With regWriteEnable=0, no register SHALL change.
REQ-018 The read SHALL occur on the rising clk edge when regReadEnable=1: RD1 <= value(A1) and RD2 <= value(A2), with 1-cycle latency.
REQ-019 value(A) SHALL be 8'h00 for A>=32.
REQ-020 With regReadEnable=0, RD1 and RD2 SHALL hold their previous values.
REQ-021 Read-during-write bypass: if the same edge writes reg[A3] and reads address A1==A3 or A2==A3 (A3<32), the corresponding RD SHALL load the new WriteData, not the old contents.
REQ-022 Both read ports SHALL operate independently; A1==A2 SHALL give identical RD1 and RD2.
REQ-023 Read and write SHALL be allowed on the same edge.
REQ-024 Outputs SHALL be driven directly from flops, with no combinational path from the inputs to RD1 or RD2.

Reset
REQ-025 When rst_n=0, all 32 registers, RD1 and RD2 SHALL clear to 8'h00 immediately, independent of clk.
REQ-026 While rst_n=0, writes and reads SHALL be blocked.
REQ-027 Normal operation SHALL resume at the first rising clk edge after rst_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight write; it SHALL have no effect after deassertion.

Verification
REQ-029 Reset, then read enable with A1=0 and A2=1 -> RD1=0 and RD2=0 after one edge.
REQ-030 Write 42 to A3=2, then read with A1=2 and A2=1 -> RD1=42 and RD2=0; then write 99 to A3=4 and read with A1=4 and A2=2 -> RD1=99 and RD2=42.
REQ-031 Write 67 to A3=1, then read with A1=1 and A2=2 -> RD1=67 and RD2=42; with regReadEnable=0 and the addresses changed, RD1 and RD2 SHALL remain 67 and 42.
REQ-032 Same-edge write of 8'hA5 to A3=3 and read with A1=3 -> RD1=8'hA5 after that edge (bypass).
REQ-033 Write with A3=40, and read with A1=40 -> RD1=0, with registers 0..31 unchanged.
REQ-034 Assert rst_n=0 between clock edges after writes -> RD1 and RD2 go to 0 immediately; subsequent reads of previously written registers -> 0.
